stream_demux_reg: RTL and testbench
===================================

Name: stream_demux_reg

Overview:
Registered, parametrised 1-to-NCH stream demultiplexer with per-channel valid/ready handshake. It is the clocked successor of the team's combinational 1-to-16 demux. An input word is captured with its destination and held until accepted. Unicast mode routes the word to the channel selected by sel. Broadcast mode delivers the word to every channel and holds it until every channel has accepted it. The block sits between a single producer and NCH consumer lanes.

Parameters:
WIDTH, 8, data word width in bits
NCH, 16, number of output channels (2..64)
SELW, 4, select width; must satisfy 2**SELW >= NCH
CNTW, 8, width of saturating drop counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
d  input  WIDTH  input data word
d_valid  input  1  input word valid
d_ready  output  1  block can accept a word this cycle
sel  input  SELW  destination channel, sampled with the input handshake
bcast  input  1  1 = broadcast to all channels, sampled with the input handshake
out_data  output  NCH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  NCH  per-channel valid
out_ready  input  NCH  per-channel ready
err  output  1  one-cycle pulse on a dropped word
drop_cnt  output  CNTW  saturating count of dropped words

Behaviour:
- Interface fixed: single clock clk; rst is asynchronous, active-high.
- Reset values: data_q=0, pend=0 (NCH-bit pending mask), err=0, drop_cnt=0. Hence out_valid=0, out_data=0, d_ready=1.
- Two states, both derived from pend:
  - EMPTY: pend==0.
  - HOLD: pend!=0.
- Outputs:
  - out_valid = pend.
  - out_data slice i = data_q when pend[i]=1, else 0. Idle lanes always read 0, never stale data.
- Channel handshake: channel i completes when pend[i] && out_ready[i]; pend[i] clears at the next edge.
- d_ready = ((pend & ~out_ready) == 0). It is combinational, so a word can be accepted in the same cycle the last pending channel drains. Back-to-back throughput is 1 word/cycle when consumers are always ready.
- Input accept (d_valid && d_ready) at edge:
  - data_q <= d.
  - bcast=1: pend <= all ones (NCH bits).
  - bcast=0 and sel < NCH: pend <= one-hot(sel).
  - bcast=0 and sel >= NCH: the word is dropped. pend <= 0, data_q is unchanged, err=1 for one cycle, drop_cnt increments and saturates at 2**CNTW-1.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N; minimum 1 cycle.
- Simultaneous drain and accept: the new mask replaces the old one, and the new word's data is presented from the next cycle.
- Broadcast partial accept: channels that already took the word drop valid; the rest keep valid and data until they accept. d_ready stays 0 until the final channel handshakes.
- out_ready on non-pending channels is ignored.
- d_valid=1 with d_ready=0: the input is not consumed. The producer must hold d, sel and bcast stable.
- err is 0 in every cycle without a drop.
- rst asserted mid-operation: pend, data_q, err and drop_cnt clear immediately (asynchronously). The held word is lost and d_ready=1 after reset release.
- NCH not a power of two: sel values NCH..2**SELW-1 are the drop case.

Test Plan:
1. Reset, then unicast sweep with all out_ready=1: d=8'hA5, sel=0..15 back-to-back -> each cycle exactly one out_valid bit set at index sel, that slice=8'hA5, all others 0, d_ready stays 1, 16 words in 16 cycles.
2. Backpressure: sel=3, d=8'h3C, out_ready[3]=0 for 5 cycles -> out_valid[3] and data held 5 cycles, d_ready=0; a second word (d=8'h11) is not accepted until out_ready[3]=1; it is accepted that same cycle and appears on its channel the next cycle.
3. Broadcast partial drain: bcast=1, d=8'h5A, out_ready=16'h00FF then 16'hFF00 -> out_valid goes 16'hFFFF, then 16'hFF00, then 16'h0000; d_ready=1 only in the second drain cycle.
4. Drop: NCH=12, SELW=4, sel=4'd13, d_valid=1 -> no out_valid asserted, err pulses once, drop_cnt 0 -> 1. Repeat 300 drops with CNTW=8 -> drop_cnt saturates at 255.
5. Async reset mid-hold: broadcast pending with out_ready=0, assert rst between clock edges -> out_valid=0, out_data=0, drop_cnt=0 before the next edge; after release d_ready=1.
6. Random regression: random d, sel, bcast and out_ready for 10k cycles against a reference queue model -> every accepted word is delivered exactly once per target channel, in order, with no word lost or duplicated.

Source files
------------

// File: rtl/stream_demux_reg_if.sv
// Producer and consumer-lane bundle for the registered stream demultiplexer.
interface stream_demux_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16,
  parameter int SELW  = 4,
  parameter int CNTW  = 8
);
  logic [WIDTH-1:0]     d;
  logic                 d_valid;
  logic                 d_ready;
  logic [SELW-1:0]      sel;
  logic                 bcast;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic                 err;
  logic [CNTW-1:0]      drop_cnt;

  modport master (
    output d, d_valid, sel, bcast, out_ready,
    input  d_ready, out_data, out_valid, err, drop_cnt
  );

  modport slave (
    input  d, d_valid, sel, bcast, out_ready,
    output d_ready, out_data, out_valid, err, drop_cnt
  );
endinterface

// File: rtl/stream_demux_reg.sv
// Registered 1-to-NCH stream demux (unicast/broadcast, drops sel >= NCH); 1-cycle latency.
// d_ready is low while any pending lane is not ready, so a held word blocks the producer.
module stream_demux_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16,
  parameter int SELW  = 4,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  stream_demux_reg_if.slave  bus
);

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam logic [NCH-1:0]  LANE0   = {{(NCH-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [NCH-1:0]       pend_q, pend_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 err_q, err_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  state_t               state;
  logic                 rdy;
  logic                 accept;
  logic                 sel_ok;
  logic [NCH*WIDTH-1:0] odat;

  // The state is a view of the pending mask, not separate storage.
  assign state  = (pend_q == '0) ? EMPTY : HOLD;
  assign sel_ok = (32'(bus.sel) < NCH);
  assign accept = bus.d_valid && rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    pend_d = pend_q & ~bus.out_ready;
    data_d = data_q;
    err_d  = 1'b0;
    cnt_d  = cnt_q;
    if (accept) begin
      if (bus.bcast) begin
        pend_d = '1;
        data_d = bus.d;
      end else if (sel_ok) begin
        pend_d = LANE0 << bus.sel;
        data_d = bus.d;
      end else begin
        // Unroutable word: consume it, keep the old data, count it.
        pend_d = '0;
        err_d  = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdy  = (state == EMPTY) || ((pend_q & ~bus.out_ready) == '0);
    odat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pend_q[i]) begin
        odat[i*WIDTH +: WIDTH] = data_q;
      end
    end
  end

  assign bus.d_ready   = rdy;
  assign bus.out_valid = pend_q;
  assign bus.out_data  = odat;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
// Directed and randomized checks of stream_demux_reg for NCH=16 and NCH=12 instances.
module tb_stream_demux_reg;

  logic clk = 1'b0;
  logic rst16, rst12;
  always #5 clk = ~clk;

  stream_demux_reg_if bus16 ();
  stream_demux_reg_if #(.NCH(12)) bus12 ();

  stream_demux_reg u_dut16 (.clk(clk), .rst(rst16), .bus(bus16));
  stream_demux_reg #(.NCH(12)) u_dut12 (.clk(clk), .rst(rst12), .bus(bus12));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the NCH=12 instance: one queue of undelivered words per lane.
  logic [7:0]  q [12][$];
  int          exp_cnt;
  bit          exp_err;
  bit          hold;
  bit          can_take;
  logic [11:0] ev;
  logic [95:0] ed;

  initial begin
    rst16 = 1'b1;
    rst12 = 1'b1;
    bus16.d = '0; bus16.d_valid = 1'b0; bus16.sel = '0; bus16.bcast = 1'b0; bus16.out_ready = '0;
    bus12.d = '0; bus12.d_valid = 1'b0; bus12.sel = '0; bus12.bcast = 1'b0; bus12.out_ready = '0;
    #12;
    check("rst_valid16", bus16.out_valid, 0);
    check("rst_data16",  bus16.out_data, 0);
    check("rst_ready16", bus16.d_ready, 1);
    check("rst_err16",   bus16.err, 0);
    check("rst_cnt16",   bus16.drop_cnt, 0);
    check("rst_valid12", bus12.out_valid, 0);
    rst16 = 1'b0;
    rst12 = 1'b0;
    step();

    // Unicast sweep, consumers always ready: one word per cycle.
    bus16.d = 8'hA5; bus16.d_valid = 1'b1; bus16.out_ready = '1;
    for (int s = 0; s < 16; s++) begin
      bus16.sel = 4'(s);
      @(negedge clk);
      check("sweep_ready", bus16.d_ready, 1);
      step();
      check("sweep_valid", bus16.out_valid, 16'h1 << s);
      check("sweep_data",  bus16.out_data, 128'hA5 << (s*8));
    end
    bus16.d_valid = 1'b0;
    step();
    check("sweep_idle", bus16.out_valid, 0);

    // Backpressure on lane 3; a second word waits for it.
    bus16.d = 8'h3C; bus16.sel = 4'd3; bus16.d_valid = 1'b1; bus16.out_ready = ~16'h0008;
    step();
    bus16.d = 8'h11; bus16.sel = 4'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus16.out_valid, 16'h0008);
      check("bp_data",  bus16.out_data, 128'h3C << 24);
      check("bp_ready", bus16.d_ready, 0);
      step();
    end
    bus16.out_ready = '1;
    @(negedge clk);
    check("bp_release_ready", bus16.d_ready, 1);
    step();
    bus16.d_valid = 1'b0;
    check("bp_next_valid", bus16.out_valid, 16'h0080);
    check("bp_next_data",  bus16.out_data, 128'h11 << 56);
    step();

    // Broadcast with a two-step partial drain.
    bus16.d = 8'h5A; bus16.bcast = 1'b1; bus16.d_valid = 1'b1; bus16.out_ready = 16'h00FF;
    step();
    bus16.d_valid = 1'b0; bus16.bcast = 1'b0;
    check("bc_valid_all", bus16.out_valid, 16'hFFFF);
    check("bc_data_all",  bus16.out_data, {16{8'h5A}});
    @(negedge clk);
    check("bc_ready_first", bus16.d_ready, 0);
    step();
    bus16.out_ready = 16'hFF00;
    check("bc_valid_half", bus16.out_valid, 16'hFF00);
    check("bc_data_half",  bus16.out_data, {{8{8'h5A}}, 64'h0});
    @(negedge clk);
    check("bc_ready_second", bus16.d_ready, 1);
    step();
    check("bc_valid_done", bus16.out_valid, 0);
    check("bc_data_done",  bus16.out_data, 0);

    // Drops on the NCH=12 instance.
    bus12.d = 8'h77; bus12.sel = 4'd13; bus12.d_valid = 1'b1; bus12.out_ready = '1;
    @(negedge clk);
    check("drop_ready", bus12.d_ready, 1);
    step();
    bus12.d_valid = 1'b0;
    check("drop_valid", bus12.out_valid, 0);
    check("drop_err",   bus12.err, 1);
    check("drop_cnt1",  bus12.drop_cnt, 1);
    step();
    check("drop_err_clear", bus12.err, 0);
    check("drop_cnt_hold",  bus12.drop_cnt, 1);
    bus12.d_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (k == 252) check("drop_cnt254", bus12.drop_cnt, 254);
    end
    check("drop_sat",       bus12.drop_cnt, 255);
    check("drop_err_burst", bus12.err, 1);
    bus12.d_valid = 1'b0;
    step();
    check("drop_sat_err_clear", bus12.err, 0);

    // Asynchronous reset while a broadcast is held.
    bus12.d = 8'hC3; bus12.bcast = 1'b1; bus12.d_valid = 1'b1; bus12.out_ready = '0;
    step();
    bus12.d_valid = 1'b0; bus12.bcast = 1'b0;
    check("hold_valid", bus12.out_valid, 12'hFFF);
    check("hold_data",  bus12.out_data, {12{8'hC3}});
    #3 rst12 = 1'b1;
    #1;
    check("arst_valid", bus12.out_valid, 0);
    check("arst_data",  bus12.out_data, 0);
    check("arst_cnt",   bus12.drop_cnt, 0);
    #2 rst12 = 1'b0;
    #1;
    check("arst_ready", bus12.d_ready, 1);
    step();
    check("arst_idle", bus12.out_valid, 0);

    // Random regression against the per-lane queue model.
    exp_cnt = 0;
    exp_err = 1'b0;
    hold    = 1'b0;
    for (int cyc = 0; cyc < 10030; cyc++) begin
      if (!hold) begin
        bus12.d_valid = (cyc < 10000) && ($urandom_range(0, 9) < 7);
        bus12.d       = 8'($urandom);
        bus12.sel     = 4'($urandom_range(0, 15));
        bus12.bcast   = ($urandom_range(0, 7) == 0);
      end
      bus12.out_ready = (cyc < 10000) ? 12'($urandom) : 12'hFFF;
      @(negedge clk);
      ev = '0;
      ed = '0;
      can_take = 1'b1;
      for (int ch = 0; ch < 12; ch++) begin
        if (q[ch].size() > 0) begin
          ev[ch] = 1'b1;
          ed[ch*8 +: 8] = q[ch][0];
          if (!bus12.out_ready[ch]) can_take = 1'b0;
        end
      end
      check("rnd_valid", bus12.out_valid, ev);
      check("rnd_data",  bus12.out_data, ed);
      check("rnd_ready", bus12.d_ready, can_take);
      check("rnd_err",   bus12.err, exp_err);
      check("rnd_cnt",   bus12.drop_cnt, exp_cnt);
      for (int ch = 0; ch < 12; ch++) begin
        if (ev[ch] && bus12.out_ready[ch]) void'(q[ch].pop_front());
      end
      exp_err = 1'b0;
      if (bus12.d_valid && can_take) begin
        hold = 1'b0;
        if (bus12.bcast) begin
          for (int ch = 0; ch < 12; ch++) q[ch].push_back(bus12.d);
        end else if (bus12.sel < 12) begin
          q[bus12.sel].push_back(bus12.d);
        end else begin
          exp_err = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end else begin
        hold = bus12.d_valid;
      end
      step();
    end
    for (int ch = 0; ch < 12; ch++) begin
      check("rnd_drained", q[ch].size(), 0);
    end
    check("rnd_final_valid", bus12.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
